// File: rtl/mf_pkg.sv
// Shared definitions for the matched-filter sequencer: state encoding,
// MIF data-type codes and the counter-width helper.
package mf_pkg;

    // Sequencer states
    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        LOAD_COEFF = 3'd1,
        WAIT_SET   = 3'd2,
        LOAD_DATA  = 3'd3,
        DRAIN      = 3'd4,
        STOP       = 3'd5
    } mfState_t;

    // MIF data-type selectors used by the read-MIF instances
    localparam int COEFF   = 1;
    localparam int DATA_IN = 2;

    // Width that holds the longest run plus the timeout margin, with one spare bit
    function automatic int calcCw(input int dataLength, input int coeffLength,
                                  input int htLatency, input int timeout);
        return $clog2(dataLength + coeffLength + htLatency + timeout) + 1;
    endfunction

endpackage

// File: rtl/mf_seq_timer.sv
// Loadable up-counter with a terminal-count compare. Used both as the
// per-state timeout/drain timer and as the issued-sample counter.
module mf_seq_timer #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] loadValue,
    input  logic         inc,
    input  logic [W-1:0] termValue,
    output logic [W-1:0] value,
    output logic         atTerm
);

    // Load has priority over increment; otherwise the count holds
    always_ff @(posedge clock) begin
        if (reset) begin
            value <= '0;
        end else if (load) begin
            value <= loadValue;
        end else if (inc) begin
            value <= value + W'(1);
        end
    end

    assign atTerm = (value == termValue);

endmodule

// File: rtl/mf_sequencer.sv
// Matched-filter sequencer: loads FIR coefficients from the MIF reader,
// streams received data through the FIR and Hilbert transform, drains the
// pipeline and reports completion. Outputs are registered decodes of the
// next state so each is valid in the first cycle of its state.
//
// Handshake flags (coeffFinishedFlag, coefficientsSetFlag, dataInFinishedFlag)
// are level signals sampled on every rising edge; a flag seen high in a cycle
// causes the state change at the end of that same cycle. There is no ready
// back-pressure: the readers and FIR are enabled for whole states.
module mf_sequencer
    import mf_pkg::*;
#(
    parameter int COEFF_LENGTH = 10000,
    parameter int DATA_LENGTH  = 33000,
    parameter int HT_LATENCY   = 27,
    parameter int TIMEOUT      = 1024,
    parameter int CW           = calcCw(DATA_LENGTH, COEFF_LENGTH, HT_LATENCY, TIMEOUT)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          enable,
    input  logic          abort,
    input  logic          coeffFinishedFlag,
    input  logic          coefficientsSetFlag,
    input  logic          dataInFinishedFlag,
    output logic          enableMFCoeff,
    output logic          loadCoefficients,
    output logic          enableMFDataIn,
    output logic          loadDataFlag,
    output logic          stopDataLoadFlag,
    output logic          enableHT,
    output logic          outputValid,
    output logic          busy,
    output logic          done,
    output logic          error,
    output logic [CW-1:0] sampleCount,
    output mfState_t      debugState,
    output logic [CW-1:0] debugTimer
);

    // Timer terminal counts; the timer reads 1 in the first cycle of a state,
    // so each value is the number of cycles the state may last.
    localparam logic [CW-1:0] COEFF_TC    = CW'(COEFF_LENGTH + TIMEOUT - 1);
    localparam logic [CW-1:0] SET_TC      = CW'(TIMEOUT);
    localparam logic [CW-1:0] DRAIN_TC    = CW'(COEFF_LENGTH - 1 + HT_LATENCY);
    localparam logic [CW-1:0] LAST_SAMPLE = CW'(DATA_LENGTH - 1);
    localparam logic [CW-1:0] SAMPLE_SAT  = CW'(DATA_LENGTH);
    localparam logic [CW-1:0] HT_THRESH   = CW'(HT_LATENCY);

    mfState_t      state;
    mfState_t      stateNext;
    logic          errorNext;

    logic [CW-1:0] timerValue;
    logic [CW-1:0] timerTerm;
    logic          timerLoad;
    logic          timerInc;
    logic          timerAtTerm;

    logic          sampleLoad;
    logic          sampleInc;
    logic          sampleAtLast;
    logic [CW-1:0] samplesAfter;

    // Timer restarts at 1 on every state change and counts while busy
    assign timerLoad = (stateNext != state);
    assign timerInc  = (state != IDLE);

    // Terminal count for the state currently being timed
    always_comb begin
        timerTerm = '0;
        case (state)
            LOAD_COEFF: timerTerm = COEFF_TC;
            WAIT_SET:   timerTerm = SET_TC;
            DRAIN:      timerTerm = DRAIN_TC;
            default:    timerTerm = '0;
        endcase
    end

    mf_seq_timer #(.W(CW)) stateTimer (
        .clock     (clock),
        .reset     (reset),
        .load      (timerLoad),
        .loadValue (CW'(1)),
        .inc       (timerInc),
        .termValue (timerTerm),
        .value     (timerValue),
        .atTerm    (timerAtTerm)
    );

    // Sample counter: cleared on an accepted start, saturates at DATA_LENGTH
    assign sampleLoad = (state == IDLE) && enable;
    assign sampleInc  = (state == LOAD_DATA) && (sampleCount < SAMPLE_SAT);

    mf_seq_timer #(.W(CW)) sampleTimer (
        .clock     (clock),
        .reset     (reset),
        .load      (sampleLoad),
        .loadValue ('0),
        .inc       (sampleInc),
        .termValue (LAST_SAMPLE),
        .value     (sampleCount),
        .atTerm    (sampleAtLast)
    );

    // Sample count as it will read after this edge, for the outputValid decode
    assign samplesAfter = sampleInc ? (sampleCount + CW'(1)) : sampleCount;

    // Next-state and sticky error; abort outranks everything, finish flags outrank timeouts
    always_comb begin
        stateNext = state;
        errorNext = error;
        case (state)
            IDLE: begin
                if (enable) begin
                    stateNext = LOAD_COEFF;
                    errorNext = 1'b0;
                end
            end
            LOAD_COEFF: begin
                if (abort) begin
                    stateNext = IDLE;
                end else if (coeffFinishedFlag) begin
                    stateNext = WAIT_SET;
                end else if (timerAtTerm) begin
                    stateNext = STOP;
                    errorNext = 1'b1;
                end
            end
            WAIT_SET: begin
                if (abort) begin
                    stateNext = IDLE;
                end else if (coefficientsSetFlag) begin
                    stateNext = LOAD_DATA;
                end else if (timerAtTerm) begin
                    stateNext = STOP;
                    errorNext = 1'b1;
                end
            end
            LOAD_DATA: begin
                if (abort) begin
                    stateNext = IDLE;
                end else if (dataInFinishedFlag || sampleAtLast) begin
                    stateNext = DRAIN;
                end
            end
            DRAIN: begin
                if (abort) begin
                    stateNext = IDLE;
                end else if (timerAtTerm) begin
                    stateNext = STOP;
                end
            end
            STOP: begin
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // State register plus registered decode of the next state onto every output
    always_ff @(posedge clock) begin
        if (reset) begin
            state            <= IDLE;
            error            <= 1'b0;
            enableMFCoeff    <= 1'b0;
            loadCoefficients <= 1'b0;
            enableMFDataIn   <= 1'b0;
            loadDataFlag     <= 1'b0;
            stopDataLoadFlag <= 1'b0;
            enableHT         <= 1'b0;
            outputValid      <= 1'b0;
            busy             <= 1'b0;
            done             <= 1'b0;
        end else begin
            state            <= stateNext;
            error            <= errorNext;
            enableMFCoeff    <= (stateNext == LOAD_COEFF);
            loadCoefficients <= (stateNext == LOAD_COEFF) || (stateNext == WAIT_SET);
            enableMFDataIn   <= (stateNext == LOAD_DATA);
            loadDataFlag     <= (stateNext == LOAD_DATA);
            stopDataLoadFlag <= (stateNext == DRAIN);
            enableHT         <= (stateNext == LOAD_DATA) || (stateNext == DRAIN);
            outputValid      <= (stateNext == DRAIN) ||
                                ((stateNext == LOAD_DATA) && (samplesAfter >= HT_THRESH));
            busy             <= (stateNext != IDLE);
            done             <= (stateNext == STOP) && !errorNext;
        end
    end

    assign debugState = state;
    assign debugTimer = timerValue;

endmodule

// File: tb/tb_mf_sequencer.sv
// Directed bench for mf_sequencer with small lengths so whole runs fit in a
// few dozen cycles. Readers and FIR are modelled reactively from the DUT
// enables; expected counts are hand-derived constants.
module tb_mf_sequencer;

    localparam int C  = 4;
    localparam int D  = 8;
    localparam int H  = 2;
    localparam int T  = 16;
    localparam int CW = mf_pkg::calcCw(D, C, H, T);
    localparam int BUDGET = 200;

    logic clock = 1'b0;
    logic reset;
    logic enable;
    logic abort;
    logic coeffFinishedFlag;
    logic coefficientsSetFlag;
    logic dataInFinishedFlag;
    logic enableMFCoeff;
    logic loadCoefficients;
    logic enableMFDataIn;
    logic loadDataFlag;
    logic stopDataLoadFlag;
    logic enableHT;
    logic outputValid;
    logic busy;
    logic done;
    logic error;
    logic [CW-1:0] sampleCount;
    logic [CW-1:0] debugTimer;
    mf_pkg::mfState_t debugState;

    logic [9:0] outVec;
    logic [5:0] enVec;

    int errors = 0;
    int checks = 0;

    // Per-run observations
    int nCoeff, nSet, nData, nDrain, nBusy, nDone, nValid, nValidOutside;
    int firstValid, lastDrainCyc, doneCyc, timedOut;

    // Clock and DUT
    always #5 clock = ~clock;

    mf_sequencer #(
        .COEFF_LENGTH (C),
        .DATA_LENGTH  (D),
        .HT_LATENCY   (H),
        .TIMEOUT      (T)
    ) dut (
        .clock               (clock),
        .reset               (reset),
        .enable              (enable),
        .abort               (abort),
        .coeffFinishedFlag   (coeffFinishedFlag),
        .coefficientsSetFlag (coefficientsSetFlag),
        .dataInFinishedFlag  (dataInFinishedFlag),
        .enableMFCoeff       (enableMFCoeff),
        .loadCoefficients    (loadCoefficients),
        .enableMFDataIn      (enableMFDataIn),
        .loadDataFlag        (loadDataFlag),
        .stopDataLoadFlag    (stopDataLoadFlag),
        .enableHT            (enableHT),
        .outputValid         (outputValid),
        .busy                (busy),
        .done                (done),
        .error               (error),
        .sampleCount         (sampleCount),
        .debugState          (debugState),
        .debugTimer          (debugTimer)
    );

    assign outVec = {enableMFCoeff, loadCoefficients, enableMFDataIn, loadDataFlag,
                     stopDataLoadFlag, enableHT, outputValid, busy, done, error};
    assign enVec  = outVec[9:4];

    // Advance one clock and settle past the edge
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic checkEq(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    // Pulse enable for one cycle
    task automatic startRun();
        enable = 1'b1;
        tick();
        enable = 1'b0;
    endtask

    // Drive the readers/FIR from the DUT enables until busy drops.
    // coeffAt: LOAD_COEFF cycle that carries the last word (0 = never)
    // dataAt: sampleCount on which the data reader finishes (-1 = never)
    // abortAt: LOAD_DATA cycle in which abort is pulsed (0 = never)
    // stopAtDrain: leave the loop in this DRAIN cycle without clocking (0 = run out)
    task automatic runBody(input int coeffAt, input int dataAt, input int abortAt, input int stopAtDrain);
        int cyc;
        cyc = 0;
        nCoeff = 0; nSet = 0; nData = 0; nDrain = 0; nBusy = 0; nDone = 0;
        nValid = 0; nValidOutside = 0; firstValid = 99; lastDrainCyc = 0; doneCyc = 0;
        while (busy && cyc < BUDGET) begin
            cyc++;
            nBusy++;
            if (enableMFCoeff) nCoeff++;
            if (loadCoefficients && !enableMFCoeff) nSet++;
            if (loadDataFlag) nData++;
            if (stopDataLoadFlag) begin
                nDrain++;
                lastDrainCyc = cyc;
            end
            if (done) begin
                nDone++;
                doneCyc = cyc;
            end
            if (outputValid) begin
                nValid++;
                if (!(loadDataFlag || stopDataLoadFlag)) nValidOutside++;
                if (loadDataFlag && firstValid == 99) firstValid = int'(sampleCount);
            end
            if (stopAtDrain != 0 && nDrain == stopAtDrain) break;
            coeffFinishedFlag   = enableMFCoeff && (nCoeff == coeffAt);
            coefficientsSetFlag = loadCoefficients && !enableMFCoeff;
            dataInFinishedFlag  = loadDataFlag && (int'(sampleCount) == dataAt);
            abort               = loadDataFlag && (nData == abortAt);
            tick();
        end
        coeffFinishedFlag   = 1'b0;
        coefficientsSetFlag = 1'b0;
        dataInFinishedFlag  = 1'b0;
        abort               = 1'b0;
        timedOut = (cyc >= BUDGET) ? 1 : 0;
    endtask

    initial begin
        reset = 1'b1;
        enable = 1'b0;
        abort = 1'b0;
        coeffFinishedFlag = 1'b0;
        coefficientsSetFlag = 1'b0;
        dataInFinishedFlag = 1'b0;
        repeat (3) tick();

        // Reset state
        checkEq("reset_outputs", outVec, 0);
        checkEq("reset_sample_count", sampleCount, 0);
        checkEq("reset_state", debugState, mf_pkg::IDLE);
        reset = 1'b0;
        tick();
        tick();
        checkEq("idle_no_start", busy, 0);

        // Normal run with ideal readers
        startRun();
        checkEq("start_coeff_enable", enableMFCoeff, 1);
        checkEq("start_busy", busy, 1);
        runBody(C, D - 1, 0, 0);
        checkEq("norm_budget", timedOut, 0);
        checkEq("norm_coeff_cycles", nCoeff, 4);
        checkEq("norm_wait_set_cycles", nSet, 1);
        checkEq("norm_data_cycles", nData, 8);
        checkEq("norm_drain_cycles", nDrain, 5);
        checkEq("norm_busy_cycles", nBusy, 19);
        checkEq("norm_done_pulses", nDone, 1);
        checkEq("norm_done_cycle", doneCyc, 19);
        checkEq("norm_last_drain_cycle", lastDrainCyc, 18);
        checkEq("norm_first_valid_count", firstValid, 2);
        checkEq("norm_valid_cycles", nValid, 11);
        checkEq("norm_valid_outside", nValidOutside, 0);
        checkEq("norm_sample_count", sampleCount, 8);
        checkEq("norm_error", error, 0);
        checkEq("norm_idle_outputs", outVec, 0);
        tick();

        // Coefficient reader never finishes
        startRun();
        runBody(0, -1, 0, 0);
        checkEq("tmo_budget", timedOut, 0);
        checkEq("tmo_coeff_cycles", nCoeff, 19);
        checkEq("tmo_busy_cycles", nBusy, 20);
        checkEq("tmo_done_pulses", nDone, 0);
        checkEq("tmo_data_cycles", nData, 0);
        checkEq("tmo_error_sticky", error, 1);
        checkEq("tmo_state", debugState, mf_pkg::IDLE);
        tick();

        // Data reader finishes early at sample 5
        startRun();
        checkEq("early_error_cleared", error, 0);
        runBody(C, 5, 0, 0);
        checkEq("early_budget", timedOut, 0);
        checkEq("early_data_cycles", nData, 6);
        checkEq("early_sample_count", sampleCount, 6);
        checkEq("early_drain_cycles", nDrain, 5);
        checkEq("early_busy_cycles", nBusy, 17);
        checkEq("early_done_pulses", nDone, 1);
        tick();

        // Abort in the third LOAD_DATA cycle
        startRun();
        runBody(C, -1, 3, 0);
        checkEq("abort_budget", timedOut, 0);
        checkEq("abort_data_cycles", nData, 3);
        checkEq("abort_busy_cycles", nBusy, 8);
        checkEq("abort_enables", enVec, 0);
        checkEq("abort_done_pulses", nDone, 0);
        checkEq("abort_sample_count", sampleCount, 3);
        checkEq("abort_state", debugState, mf_pkg::IDLE);
        tick();
        checkEq("abort_no_late_done", done, 0);
        checkEq("abort_stays_idle", busy, 0);

        // Enable held high: timeout run, one IDLE cycle, then a clean run
        enable = 1'b1;
        tick();
        runBody(0, -1, 0, 0);
        checkEq("held_first_budget", timedOut, 0);
        checkEq("held_first_coeff_cycles", nCoeff, 19);
        checkEq("held_idle_gap", busy, 0);
        checkEq("held_idle_error", error, 1);
        tick();
        checkEq("held_restart_busy", busy, 1);
        checkEq("held_restart_coeff", enableMFCoeff, 1);
        checkEq("held_restart_error", error, 0);
        enable = 1'b0;
        runBody(C, -1, 0, 0);
        checkEq("held_second_budget", timedOut, 0);
        checkEq("held_second_busy_cycles", nBusy, 19);
        checkEq("held_second_data_cycles", nData, 8);
        checkEq("held_second_done_pulses", nDone, 1);
        checkEq("held_second_sample_count", sampleCount, 8);
        tick();

        // Reset during DRAIN
        startRun();
        runBody(C, -1, 0, 2);
        checkEq("rst_in_drain", stopDataLoadFlag, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkEq("rst_outputs", outVec, 0);
        checkEq("rst_sample_count", sampleCount, 0);
        checkEq("rst_state", debugState, mf_pkg::IDLE);
        tick();
        checkEq("rst_stays_idle", busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
